// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared FSM state type, default 640x480@60 timing constants and a total-count helper.
package vga_timing_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: single-axis raster counter (active, front porch, sync, back porch).
// Ports: clk, rst (sync active-high), en (advance) -> cnt, wrap (en at last count), active, sync_on.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP = DEF_H_BP,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync_on
);
  localparam logic [W-1:0] LAST = W'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);
  always_ff @(posedge clk)
    cnt <= rst ? '0 : wrap ? '0 : en ? cnt + W'(1) : cnt;
  always_comb begin
    wrap = en && cnt == LAST;
    active = cnt < ACT_END;
    sync_on = cnt >= SYNC_BEG && cnt < SYNC_END;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/DVI raster timing generator with FIFO read alignment and underflow flagging.
// Ports: clk, rst (sync active-high), cfg_done, fifo_empty -> rd_fifo, hsync, vsync, comp_sync, blank,
//   pixel_x, pixel_y, frame_start, running, underflow, underflow_cnt.
// Define VGA_TIMING_UNDERFLOW_CNT_EN to implement the 16-bit saturating underflow_cnt (else tied to 0).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit H_POL = 1'b0,
  parameter bit V_POL = 1'b0,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_done,
  input  logic             fifo_empty,
  output logic             rd_fifo,
  output logic             hsync,
  output logic             vsync,
  output logic             comp_sync,
  output logic             blank,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start,
  output logic             running,
  output logic             underflow,
  output logic [15:0]      underflow_cnt
);
  logic [CNT_W-1:0] h_cnt, v_cnt, h1, v1;
  logic h_wrap, h_act, h_sync, v_wrap, v_act, v_sync;
  logic live, rd_d, uf_d, vis1, hs1, vs1;
  state_t state, state_n;
  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(CNT_W)) u_h (
    .clk(clk), .rst(rst), .en(1'b1), .cnt(h_cnt), .wrap(h_wrap), .active(h_act), .sync_on(h_sync)
  );
  // v_wrap is the frame wrap: last line and last pixel of that line
  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(CNT_W)) u_v (
    .clk(clk), .rst(rst), .en(h_wrap), .cnt(v_cnt), .wrap(v_wrap), .active(v_act), .sync_on(v_sync)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (cfg_done ? ARM : IDLE)
            : state == ARM  ? (cfg_done && !fifo_empty && v_wrap ? RUN : ARM)
            : (cfg_done ? RUN : IDLE);
  // decisions use the next state so a falling cfg_done kills rd_fifo on the very next cycle
  always_comb begin
    live = state_n == RUN;
    rd_d = live && h_act && v_act && !fifo_empty;
    uf_d = live && h_act && v_act && fifo_empty;
    running = state == RUN;
  end
  // stage 1 (rd_fifo and delayed counts), stage 2 (video outputs) so FIFO dout meets blank=0
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_fifo <= 1'b0;
      underflow <= 1'b0;
      vis1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      h1 <= '0;
      v1 <= '0;
      blank <= 1'b1;
      hsync <= ~H_POL;
      vsync <= ~V_POL;
      comp_sync <= 1'b1;
      pixel_x <= '0;
      pixel_y <= '0;
      frame_start <= 1'b0;
    end else begin
      rd_fifo <= rd_d;
      underflow <= uf_d;
      vis1 <= live && h_act && v_act;
      hs1 <= h_sync;
      vs1 <= v_sync;
      h1 <= h_cnt;
      v1 <= v_cnt;
      blank <= !vis1;
      hsync <= hs1 ? H_POL : ~H_POL;
      vsync <= vs1 ? V_POL : ~V_POL;
      comp_sync <= !(hs1 || vs1);
      pixel_x <= h1;
      pixel_y <= v1;
      frame_start <= vis1 && h1 == '0 && v1 == '0;
    end
  end
`ifdef VGA_TIMING_UNDERFLOW_CNT_EN
  always_ff @(posedge clk)
    underflow_cnt <= rst ? '0 : (uf_d && underflow_cnt != 16'hFFFF) ? underflow_cnt + 16'd1 : underflow_cnt;
`else
  assign underflow_cnt = '0;
`endif
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/DVI raster timing generator; successor to the fixed 640x480 `vga_logic`. Produces hsync/vsync/blank/composite sync and pixel coordinates for any resolution and polarity, and issues FIFO read strobes aligned so a 1-cycle-latency FIFO's `dout` lines up with active video. It also gates start-up on DVI I2C configuration done and FIFO fill, and flags FIFO underflow. Sits between the pixel FIFO and the DVI transmitter, in the 25 MHz pixel-clock domain.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync width (lines)
- `V_BP`, 33: vertical back porch (lines)
- `H_POL`, 0: hsync active level (0 = active-low)
- `V_POL`, 0: vsync active level
- `CNT_W`, 11: counter / coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous, active-high reset
- `cfg_done`  in  1  DVI I2C configuration complete
- `fifo_empty`  in  1  pixel FIFO empty
- `rd_fifo`  out  1  FIFO read enable
- `hsync`, `vsync`  out  1  syncs at configured polarity
- `comp_sync`  out  1  active-low composite sync, low when either sync is asserted
- `blank`  out  1  high outside active video or when not running
- `pixel_x`, `pixel_y`  out  CNT_W  coordinates, valid while `blank` is low
- `frame_start`  out  1  one-cycle pulse aligned with first active pixel of a frame
- `running`  out  1  FSM in RUN
- `underflow`  out  1  one-cycle pulse on a missed pixel
- `underflow_cnt`  out  16  saturating miss count

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Per axis the order is active, front porch, sync, back porch, starting at count 0.
- `h_cnt` increments every cycle and wraps H_TOTAL-1 -> 0. `v_cnt` increments on each h wrap and wraps V_TOTAL-1 -> 0.
- Counters and syncs run in every state. The monitor always sees valid timing.
- FSM:
  - IDLE -> ARM when `cfg_done`.
  - ARM -> RUN at the cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, if `cfg_done` and `!fifo_empty`; otherwise stay in ARM.
  - RUN -> IDLE immediately when `cfg_done` falls.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- In RUN and active:
  - `!fifo_empty`: `rd_fifo`=1.
  - `fifo_empty`: `rd_fifo`=0, `underflow` pulses, and `underflow_cnt` increments, saturating at 0xFFFF.
  - The FIFO is never read while empty. RUN is kept; the missing pixel is simply skipped, so the downstream stream slips.
- Outside RUN: `rd_fifo`=0, `blank`=1, `frame_start`=0, no underflow.
- Arithmetic is unsigned at CNT_W. Comparisons use localparam boundaries computed at elaboration.

## Timing
- Stage 0: counters.
- Stage 1: registered `rd_fifo`, computed from stage-0 counts.
- Stage 2: registered `blank`, `hsync`, `vsync`, `comp_sync`, `pixel_x`, `pixel_y`, `frame_start`, computed from stage-0 counts delayed one cycle.
- Result: FIFO `dout` (valid the cycle after `rd_fifo`) coincides with `blank`=0 for the same pixel.
- Latency from counter value to video outputs: 2 cycles. To `rd_fifo`: 1 cycle.
- `underflow` is asserted in the same cycle `rd_fifo` would have been.
- Reset values:
  - counters 0; FSM IDLE
  - `rd_fifo` 0, `blank` 1, `frame_start` 0, `underflow` 0, `running` 0, `underflow_cnt` 0, `pixel_x`/`pixel_y` 0
  - `hsync`/`vsync` at inactive level (~H_POL, ~V_POL); `comp_sync` 1
- Reset mid-line: all of the above take effect the next cycle. The pipeline is flushed and no stale `rd_fifo` is emitted.
- `cfg_done` falling during RUN: `rd_fifo` goes low in the next cycle. Stage-2 `blank` rises one cycle later.
- `cfg_done` and the ARM trigger in the same cycle with `fifo_empty`=1: remain in ARM.

## Configuration
- `VGA_TIMING_UNDERFLOW_CNT_EN` defined: 16-bit saturating `underflow_cnt` implemented; clears only on `rst`.
- Not defined: `underflow_cnt` is tied to 0 and no counter is inferred. The `underflow` pulse is always present.

## Structure
- Package `vga_timing_pkg`:
  - FSM state typedef (IDLE, ARM, RUN)
  - default 640x480@60 timing constants
  - helper function computing totals
- One sub-module, `vga_axis_counter`: parametrised single-axis counter with wrap flag and active/sync decode. Instantiated once for H and once for V, with V enabled by the H wrap.

## Test plan
- Small config (H 8/2/2/2, V 4/1/1/1, total 14x7), `cfg_done`=1, FIFO never empty -> after reset, ARM then RUN at first frame wrap. Per line: `rd_fifo` high 8 cycles; `blank` low 8 cycles, starting exactly 1 cycle after the first `rd_fifo`. `hsync` low for 2 cycles starting 10 cycles after `blank` falls. `frame_start` once per 98 cycles.
- Same config, `cfg_done`=0 for 3 frames -> syncs toggle normally, `rd_fifo`=0, `blank`=1 throughout, `running`=0.
- Force `fifo_empty`=1 for pixel x=3 of line 1 -> `rd_fifo` low that cycle, one `underflow` pulse, `underflow_cnt`=1 with the macro (0 without), `running` stays 1.
- `fifo_empty`=1 at the ARM frame-wrap cycle -> stays in ARM a full extra frame, then enters RUN on the next wrap with FIFO non-empty.
- Assert `rst` mid-active-line in RUN -> next cycle all outputs at reset values, h/v counters 0, no `rd_fifo`. Re-arm requires a new frame wrap.
- H_POL=1, V_POL=1, 640x480 defaults -> 800x525 total; `hsync` high for 96 cycles; `vsync` high for 2 lines; `comp_sync` low whenever either sync is asserted.
